// File: rtl/div_sequencer.sv
// Multi-cycle signed radix-2 restoring divider with valid/ready handshakes.
// Optional build macro DIV_EARLY_EXIT_EN skips the dividend's leading zeros to cut latency.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_dvsr_mag;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_quo;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_out_valid;
    logic             r_dbz;
    logic             r_ovf;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvsr_mag;
    logic             w_dvsr_zero;
    logic             w_min_by_neg1;
    logic [CW-1:0]    w_iter_n;
    logic [WIDTH-1:0] w_aligned;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    assign w_dvd_mag     = r_dividend[WIDTH-1] ? -r_dividend : r_dividend;
    assign w_dvsr_mag    = r_divisor[WIDTH-1]  ? -r_divisor  : r_divisor;
    assign w_dvsr_zero   = (r_divisor == '0);
    assign w_min_by_neg1 = (r_dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (r_divisor == '1);

`ifdef DIV_EARLY_EXIT_EN
    function automatic logic [CW-1:0] f_lzc(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) n = CW'(WIDTH - 1 - i);
        end
        return n;
    endfunction

    logic [CW-1:0] w_lz;
    assign w_lz      = f_lzc(w_dvd_mag);
    assign w_iter_n  = CW'(WIDTH) - w_lz;
    assign w_aligned = w_dvd_mag << w_lz;
`else
    assign w_iter_n  = CW'(WIDTH);
    assign w_aligned = w_dvd_mag;
`endif

    // One restoring step: shift the next dividend bit into the partial remainder, trial-subtract.
    assign w_shift = {r_part, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvsr_mag};

    assign in_ready    = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_next = LOAD;
            LOAD: begin
                if (w_dvsr_zero)          w_state_next = DONE;
                else if (w_iter_n == '0)  w_state_next = FIX;
                else                      w_state_next = ITER;
            end
            ITER: if (r_cnt == CW'(1)) w_state_next = FIX;
            FIX:  w_state_next = DONE;
            DONE: if (r_out_valid && out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_dvsr_mag  <= '0;
            r_part      <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_out_valid <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dividend <= dividend;
                        r_divisor  <= divisor;
                        r_dbz      <= 1'b0;
                        r_ovf      <= 1'b0;
                    end
                end
                LOAD: begin
                    r_dvsr_mag <= w_dvsr_mag;
                    r_neg_q    <= r_dividend[WIDTH-1] ^ r_divisor[WIDTH-1];
                    r_neg_r    <= r_dividend[WIDTH-1];
                    r_part     <= '0;
                    r_quo      <= w_aligned;
                    r_cnt      <= w_iter_n;
                    r_ovf      <= w_min_by_neg1;
                    if (w_dvsr_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_dividend;
                        r_dbz       <= 1'b1;
                    end
                end
                ITER: begin
                    r_part <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                    r_quo  <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
                    r_cnt  <= r_cnt - CW'(1);
                end
                FIX: begin
                    r_quotient  <= r_neg_q ? -r_quo  : r_quo;
                    r_remainder <= r_neg_r ? -r_part : r_part;
                end
                DONE: begin
                    // Valid rises one cycle after the result registers settle.
                    if (!r_out_valid)   r_out_valid <= 1'b1;
                    else if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Randomised and directed bench for div_sequencer against a plain-arithmetic reference.
module tb_div_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_result(input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] q, output logic [31:0] r,
                              output logic z, output logic o);
        longint la;
        longint lb;
        la = $signed(a);
        lb = $signed(b);
        z  = (b == 32'd0);
        o  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (z) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = 32'(la / lb);
            r = 32'(la % lb);
        end
    endtask

    function automatic int ref_latency(input logic [31:0] a, input logic [31:0] b);
        longint m;
        int     n;
        if (b == 32'd0) return 2;
`ifdef DIV_EARLY_EXIT_EN
        m = $signed(a);
        if (m < 0) m = -m;
        n = 0;
        while (m > 0) begin
            n++;
            m = m >> 1;
        end
        return n + 3;
`else
        m = 0;
        n = W;
        return n + 3 + int'(m);
`endif
    endfunction

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold, input bit noise);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        logic        eo;
        int          lat;
        ref_result(a, b, eq, er, ez, eo);
        accept(a, b);
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (noise) in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        $display("op %h / %h -> q=%h r=%h dbz=%0b ovf=%0b latency=%0d",
                 a, b, quotient, remainder, div_by_zero, overflow, lat);
        check("latency", 64'(lat), 64'(ref_latency(a, b)));
        check("quotient", 64'(quotient), 64'(eq));
        check("remainder", 64'(remainder), 64'(er));
        check("flags", 64'({div_by_zero, overflow}), 64'({ez, eo}));
        check("busy_in_done", 64'({busy, in_ready}), 64'b10);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stable", {out_valid, in_ready, quotient, remainder}, {1'b1, 1'b0, eq, er});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("after_handshake", 64'({in_ready, out_valid, busy}), 64'b100);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({in_ready, out_valid, busy, div_by_zero, overflow}), 64'b10000);
        check("reset_data", {quotient, remainder}, 64'd0);
        rst = 1'b0;

        run_op(32'd100, 32'd7, 5, 1'b1);
        run_op(-32'sd100, 32'd7, 1, 1'b0);
        run_op(32'd5, 32'd0, 2, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
        run_op(32'd0, 32'd9, 0, 1'b0);
        run_op(32'd100, -32'sd7, 1, 1'b0);

        // Asynchronous reset in the middle of an iteration.
        accept(32'd100, 32'd7);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_ctrl", 64'({in_ready, out_valid, busy, div_by_zero, overflow}), 64'b10000);
        check("async_reset_data", {quotient, remainder}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd100, 32'd7, 2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            case (sel)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 1000));
                4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                5: begin a = 32'($urandom_range(0, 3)); b = 32'($urandom_range(1, 5)); end
                default: ;
            endcase
            run_op(a, b, $urandom_range(0, 3), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the dividend, divisor, quotient and remainder width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  dividend/divisor present.
REQ-005 SHALL have port in_ready  output  1  block accepts an operand pair.
REQ-006 SHALL have port dividend  input  WIDTH  signed two's-complement dividend.
REQ-007 SHALL have port divisor  input  WIDTH  signed two's-complement divisor.
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port quotient  output  WIDTH  signed quotient.
REQ-011 SHALL have port remainder  output  WIDTH  signed remainder.
REQ-012 SHALL have port div_by_zero  output  1  divisor was zero.
REQ-013 SHALL have port overflow  output  1  most-negative / -1 case.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, ITER, FIX and DONE.
REQ-016 SHALL drive in_ready as (state == IDLE), which is combinational from state.
REQ-017 SHALL, on an IDLE cycle with in_valid && in_ready, register the operands and go to LOAD.
REQ-018 SHALL, in LOAD, take the magnitudes |dividend| and |divisor| as WIDTH-bit unsigned values and record both signs.
REQ-019 SHALL, in LOAD, compute the iteration count N and the start alignment from the leading-zero count of |dividend| (see REQ-032).
REQ-020 SHALL, in LOAD with divisor == 0, go directly to DONE with quotient = all ones, remainder = dividend and div_by_zero = 1.
REQ-021 SHALL, in LOAD with N == 0, go to FIX; otherwise it SHALL go to ITER.
REQ-022 SHALL, in ITER, perform one radix-2 restoring step per cycle (shift the partial remainder left, trial-subtract |divisor|, shift in one quotient bit), N cycles in total, then go to FIX.
REQ-023 SHALL, in FIX, negate the quotient when the operand signs differ and negate the remainder when the dividend is negative, then go to DONE.
REQ-024 SHALL truncate the quotient toward zero; the remainder SHALL carry the dividend's sign, with |remainder| < |divisor|.
REQ-025 SHALL, for dividend = most negative and divisor = -1, return quotient = most negative, remainder = 0 and overflow = 1.
REQ-026 SHALL assert out_valid exactly N+3 cycles after the accepting edge, or 2 cycles after it when the divisor is zero.
REQ-027 SHALL hold out_valid and all result outputs stable in DONE until out_ready is high.
REQ-028 SHALL, on out_valid && out_ready, return to IDLE; in_ready SHALL rise the next cycle, with no same-cycle back-to-back accept.
REQ-029 SHALL ignore in_valid in every state except IDLE.
REQ-030 SHALL clear the div_by_zero and overflow flags on every accept.

Reset
REQ-031 SHALL, while rst is high, immediately force state = IDLE and quotient, remainder, out_valid, div_by_zero, overflow and busy to 0; in_ready SHALL read 1, and this SHALL hold even mid-ITER or in DONE, discarding any operation in flight.

Configuration
REQ-032 SHALL, with DIV_EARLY_EXIT_EN defined, set N = WIDTH - lz(|dividend|) and pre-align the dividend so the leading zeros are skipped; without the macro, N SHALL be WIDTH for every nonzero divisor and no leading-zero logic SHALL be built; results SHALL be identical in both builds, and only latency SHALL differ.

Verification
REQ-033 SHALL cover: 100 / 7 with DIV_EARLY_EXIT_EN -> quotient 14, remainder 2, N = 7, out_valid 10 cycles after accept; without the macro, out_valid 35 cycles after accept.
REQ-034 SHALL cover: -100 / 7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; 100 / -7 -> quotient 0xFFFFFFF2, remainder 2.
REQ-035 SHALL cover: 5 / 0 -> quotient 0xFFFFFFFF, remainder 5, div_by_zero = 1, out_valid 2 cycles after accept.
REQ-036 SHALL cover: 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, overflow = 1; 0 / 9 -> quotient 0, remainder 0, out_valid 3 cycles after accept (with the macro).
REQ-037 SHALL cover: out_ready held low for 5 cycles in DONE -> outputs stable and in_ready = 0 throughout; then handshake -> IDLE, in_ready = 1 the next cycle, and in_valid pulses during busy are ignored.
REQ-038 SHALL cover: rst pulsed during ITER -> outputs 0 and in_ready = 1 without waiting for a clock edge; then a new 100 / 7 after release -> correct result.
